ins_fetch: RTL and testbench

Instruction fetch stage of the 8051 core; sits directly upstream of the instruction decoder.
- Owns the program counter and reads 1–3 instruction bytes from program ROM over a req/ack handshake.
- Presents opcode plus operands to the decoder with a valid/ready handshake.
- Accepts PC redirects (jumps, calls, returns) from the execute side, discarding any in-flight fetch.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ins_len_lut.sv | 68 ++++++
 rtl/ins_fetch.sv | 131 +++++++++++++
 tb/tb_ins_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared 8051 core definitions: fetch FSM encodings, instruction length codes
// and opcodes referenced by the fetch stage and its bench.
package cpu_pkg;

    localparam int unsigned LEN_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_OP = 3'd1,
        ST_REQ_B1 = 3'd2,
        ST_REQ_B2 = 3'd3,
        ST_HOLD   = 3'd4
    } fetch_state_t;

    localparam logic [LEN_W-1:0] LEN1 = 2'd1;
    localparam logic [LEN_W-1:0] LEN2 = 2'd2;
    localparam logic [LEN_W-1:0] LEN3 = 2'd3;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_LJMP        = 8'h02;
    localparam logic [7:0] OP_MOV_A_IMM   = 8'h74;
    localparam logic [7:0] OP_MOV_DIR_IMM = 8'h75;
    localparam logic [7:0] OP_SJMP        = 8'h80;
    localparam logic [7:0] OP_MOV_DPTR    = 8'h90;
    localparam logic [7:0] OP_MOV_RN_A    = 8'b1111_1xxx;

endpackage

// File: rtl/ins_len_lut.sv
// MCS-51 opcode-to-length table covering all 256 opcodes (combinational).
module ins_len_lut
    import cpu_pkg::*;
(
    input  logic [7:0]       opcode,
    output logic [LEN_W-1:0] len_c
);

    logic [3:0] hi;
    logic [3:0] lo;

    assign hi = opcode[7:4];
    assign lo = opcode[3:0];

    // Column-wise decode: x1 is always AJMP/ACALL, x6..xF are @Ri/Rn forms.
    always_comb begin
        len_c = LEN1;
        if (lo == 4'h1) begin
            len_c = LEN2;
        end else if (lo >= 4'h6) begin
            case (hi)
                4'h7, 4'h8, 4'hA: len_c = LEN2;
                4'hB:             len_c = LEN3;
                4'hD:             len_c = lo[3] ? LEN2 : LEN1;
                default:          len_c = LEN1;
            endcase
        end else begin
            case (lo)
                4'h0: begin
                    case (hi)
                        4'h0, 4'hE, 4'hF:       len_c = LEN1;
                        4'h1, 4'h2, 4'h3, 4'h9: len_c = LEN3;
                        default:                len_c = LEN2;
                    endcase
                end
                4'h2: begin
                    case (hi)
                        4'h0, 4'h1:             len_c = LEN3;
                        4'h2, 4'h3, 4'hE, 4'hF: len_c = LEN1;
                        default:                len_c = LEN2;
                    endcase
                end
                4'h3: begin
                    case (hi)
                        4'h4, 4'h5, 4'h6: len_c = LEN3;
                        default:          len_c = LEN1;
                    endcase
                end
                4'h4: begin
                    case (hi)
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: len_c = LEN2;
                        4'hB:                                     len_c = LEN3;
                        default:                                  len_c = LEN1;
                    endcase
                end
                4'h5: begin
                    case (hi)
                        4'h7, 4'h8, 4'hB, 4'hD: len_c = LEN3;
                        4'hA:                   len_c = LEN1;
                        default:                len_c = LEN2;
                    endcase
                end
                default: len_c = LEN1;
            endcase
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// 8051 instruction fetch: owns the PC, reads 1-3 bytes from program ROM and
// hands complete instructions to the decoder; supports PC redirects.
module ins_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    input  logic              rom_ack,
    output logic [7:0]        instruction,
    output logic [7:0]        operand1,
    output logic [7:0]        operand2,
    output logic [LEN_W-1:0]  ins_len,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [PC_W-1:0]   pc_next,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_load_val
);

    fetch_state_t state, state_d;

    logic [PC_W-1:0]  pc, pc_d;
    logic [PC_W-1:0]  redirect_pc, redirect_pc_d;
    logic             flush_pend, flush_pend_d;
    logic [7:0]       instruction_d, operand1_d, operand2_d;
    logic [LEN_W-1:0] ins_len_d;
    logic [PC_W-1:0]  pc_next_d;
    logic [LEN_W-1:0] lut_len_c;
    logic             in_req;

    ins_len_lut u_len_lut (
        .opcode (rom_data),
        .len_c  (lut_len_c)
    );

    assign in_req = (state == ST_REQ_OP) || (state == ST_REQ_B1) || (state == ST_REQ_B2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
            flush_pend  <= 1'b0;
            rom_addr    <= RESET_PC;
            rom_rd      <= 1'b0;
            instruction <= 8'h00;
            operand1    <= 8'h00;
            operand2    <= 8'h00;
            ins_len     <= LEN1;
            ins_valid   <= 1'b0;
            pc_next     <= RESET_PC;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            redirect_pc <= redirect_pc_d;
            flush_pend  <= flush_pend_d;
            rom_addr    <= pc_d;
            rom_rd      <= (state_d == ST_REQ_OP) || (state_d == ST_REQ_B1) ||
                           (state_d == ST_REQ_B2);
            instruction <= instruction_d;
            operand1    <= operand1_d;
            operand2    <= operand2_d;
            ins_len     <= ins_len_d;
            ins_valid   <= (state_d == ST_HOLD);
            pc_next     <= pc_next_d;
        end
    end

    // Next-state logic; pc_load outranks both rom_ack and ins_ready.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        redirect_pc_d = redirect_pc;
        flush_pend_d  = flush_pend;
        instruction_d = instruction;
        operand1_d    = operand1;
        operand2_d    = operand2;
        ins_len_d     = ins_len;

        if (in_req) begin
            if (pc_load && rom_ack) begin
                pc_d         = pc_load_val;
                flush_pend_d = 1'b0;
                state_d      = ST_REQ_OP;
            end else if (pc_load) begin
                // The outstanding read must still complete; remember where to go after it.
                redirect_pc_d = pc_load_val;
                flush_pend_d  = 1'b1;
            end else if (rom_ack && flush_pend) begin
                pc_d         = redirect_pc;
                flush_pend_d = 1'b0;
                state_d      = ST_REQ_OP;
            end else if (rom_ack) begin
                pc_d = pc + PC_W'(1);
                case (state)
                    ST_REQ_OP: begin
                        instruction_d = rom_data;
                        operand1_d    = 8'h00;
                        operand2_d    = 8'h00;
                        ins_len_d     = lut_len_c;
                        state_d       = (lut_len_c == LEN1) ? ST_HOLD : ST_REQ_B1;
                    end
                    ST_REQ_B1: begin
                        operand1_d = rom_data;
                        state_d    = (ins_len == LEN2) ? ST_HOLD : ST_REQ_B2;
                    end
                    default: begin
                        operand2_d = rom_data;
                        state_d    = ST_HOLD;
                    end
                endcase
            end
        end else if (pc_load) begin
            pc_d    = pc_load_val;
            state_d = ST_REQ_OP;
        end else if (state == ST_IDLE) begin
            state_d = ST_REQ_OP;
        end else if (ins_valid && ins_ready) begin
            state_d = ST_REQ_OP;
        end

        pc_next_d = (state_d == ST_HOLD) ? pc_d : pc_next;
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a latency-programmable ROM model and an
// issue scoreboard of expected instructions.
module tb_ins_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic [7:0]  instruction;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [1:0]  ins_len;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] pc_next;
    logic        pc_load;
    logic [15:0] pc_load_val;

    logic [7:0]  mem [0:65535];
    int          lat;
    int          wait_cnt;

    int checks = 0;
    int errors = 0;

    logic [41:0] sb [$];
    logic        pend_q;
    logic [15:0] pend_addr;

    ins_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_data    (rom_data),
        .rom_ack     (rom_ack),
        .instruction (instruction),
        .operand1    (operand1),
        .operand2    (operand2),
        .ins_len     (ins_len),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: acks after `lat` wait cycles (lat=0 is zero-wait)
    assign rom_ack  = rom_rd && (wait_cnt >= lat);
    assign rom_data = mem[rom_addr];

    always @(posedge clk) begin
        if (rom_rd && !rom_ack) wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] ent(input logic [7:0] i, input logic [7:0] o1,
                                        input logic [7:0] o2, input logic [1:0] l,
                                        input logic [15:0] pn);
        return {i, o1, o2, l, pn};
    endfunction

    // One clock: sample before the edge, then step past it
    task automatic tick();
        logic        have;
        logic [41:0] e;
        @(negedge clk);
        if (rom_rd && pend_q) check("rom_addr_stable", 64'(rom_addr), 64'(pend_addr));
        pend_q    = rom_rd && !rom_ack;
        pend_addr = rom_addr;
        if (ins_valid && ins_ready) begin
            have = (sb.size() > 0);
            check("issue_expected", 64'(have), 64'd1);
            if (have) begin
                e = sb.pop_front();
                check("xfer", 64'({instruction, operand1, operand2, ins_len, pc_next}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!ins_valid && n < maxc) begin
            tick();
            n++;
        end
        check("wait_valid", 64'(ins_valid), 64'd1);
    endtask

    task automatic wait_addr(input logic [15:0] a, input int maxc);
        int n = 0;
        while (!(rom_rd && rom_addr == a) && n < maxc) begin
            tick();
            n++;
        end
        check("wait_addr", 64'({rom_rd, rom_addr}), 64'({1'b1, a}));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = OP_NOP;     mem[16'h0001] = 8'hF9;
        mem[16'h0002] = 8'hE4;
        mem[16'h0010] = OP_MOV_DIR_IMM; mem[16'h0011] = 8'h30; mem[16'h0012] = 8'h5A;
        mem[16'h0013] = OP_MOV_A_IMM;   mem[16'h0014] = 8'h12;
        mem[16'h0015] = OP_SJMP;        mem[16'h0016] = 8'hFE;
        mem[16'h0100] = 8'hE4;
        mem[16'h0200] = OP_MOV_DPTR;    mem[16'h0201] = 8'h12; mem[16'h0202] = 8'h34;
        mem[16'h0203] = 8'hE4;
        mem[16'hFFFF] = 8'hF8;
        mem[16'h0300] = OP_LJMP;        mem[16'h0301] = 8'h03; mem[16'h0302] = 8'h00;

        rst = 1'b1; ins_ready = 1'b1; pc_load = 1'b0; pc_load_val = 16'h0000;
        lat = 0; pend_q = 1'b0; pend_addr = 16'h0000;
        tick(); tick();

        // Reset state
        check("rst_rom_rd", 64'(rom_rd), 64'd0);
        check("rst_valid", 64'(ins_valid), 64'd0);
        check("rst_ins", 64'({instruction, operand1, operand2}), 64'd0);
        check("rst_len", 64'(ins_len), 64'd1);
        check("rst_addr", 64'(rom_addr), 64'h0000);

        // Zero-wait 1-byte instructions back to back
        rst = 1'b0;
        sb.push_back(ent(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001));
        sb.push_back(ent(8'hF9, 8'h00, 8'h00, 2'd1, 16'h0002));
        check("idle_no_rd", 64'(rom_rd), 64'd0);
        tick();
        check("first_rd", 64'({rom_rd, rom_addr}), 64'({1'b1, 16'h0000}));
        tick();
        check("first_valid", 64'(ins_valid), 64'd1);
        tick();
        check("second_rd", 64'({rom_rd, rom_addr}), 64'({1'b1, 16'h0001}));
        drain(20);

        // Redirect to 0010h with a two-cycle ROM; 3-byte instruction
        lat = 2; pc_load = 1'b1; pc_load_val = 16'h0010;
        sb.push_back(ent(8'h75, 8'h30, 8'h5A, 2'd3, 16'h0013));
        tick();
        pc_load = 1'b0;
        drain(40);

        // Backpressure on a 2-byte instruction
        lat = 0; ins_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({instruction, operand1, ins_len, ins_valid, rom_rd}),
                  64'({8'h74, 8'h12, 2'd2, 1'b1, 1'b0}));
            tick();
        end
        sb.push_back(ent(8'h74, 8'h12, 8'h00, 2'd2, 16'h0015));
        ins_ready = 1'b1;
        drain(10);
        check("bp_released", 64'(ins_valid), 64'd0);

        // Redirect while REQ_B1 waits; second load wins
        lat = 3;
        sb.push_back(ent(8'h90, 8'h12, 8'h34, 2'd3, 16'h0203));
        wait_addr(16'h0016, 20);
        pc_load = 1'b1; pc_load_val = 16'h0100;
        tick();
        pc_load_val = 16'h0200;
        tick();
        pc_load = 1'b0;
        wait_addr(16'h0200, 20);
        drain(40);

        // PC wrap at FFFFh
        lat = 0; pc_load = 1'b1; pc_load_val = 16'hFFFF;
        sb.push_back(ent(8'hF8, 8'h00, 8'h00, 2'd1, 16'h0000));
        tick();
        pc_load = 1'b0;
        drain(20);
        check("wrap_fetch", 64'({rom_rd, rom_addr}), 64'({1'b1, 16'h0000}));

        // Redirect in HOLD together with ins_ready: issued once, then fetch at 0300h
        ins_ready = 1'b0;
        wait_valid(20);
        sb.push_back(ent(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001));
        pc_load = 1'b1; pc_load_val = 16'h0300; ins_ready = 1'b1; lat = 2;
        tick();
        pc_load = 1'b0;
        check("hold_load_valid", 64'(ins_valid), 64'd0);
        check("hold_load_rd", 64'({rom_rd, rom_addr}), 64'({1'b1, 16'h0300}));
        check("hold_load_sb", 64'(sb.size()), 64'd0);

        // Async reset during REQ_B2
        wait_addr(16'h0302, 30);
        rst = 1'b1;
        #1;
        check("arst_rd", 64'(rom_rd), 64'd0);
        check("arst_valid", 64'(ins_valid), 64'd0);
        check("arst_addr", 64'(rom_addr), 64'h0000);
        pend_q = 1'b0;
        tick();
        rst = 1'b0; lat = 0;
        sb.push_back(ent(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001));
        sb.push_back(ent(8'hF9, 8'h00, 8'h00, 2'd1, 16'h0002));
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
